// File: rtl/uart_rx_pkg.sv
// Shared constants and FSM state encoding for the 8N1 UART receiver.
package uart_rx_pkg;

    localparam int UART_DBITS        = 8;
    localparam int UART_OVERSAMPLE   = 16;
    localparam int UART_BAUD_DIVISOR = 651;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_baud_rate_generator.sv
// Free-running divider producing a one-clk oversample tick every DIVISOR clocks.
module baud_rate_generator
    import uart_rx_pkg::*;
#(
    parameter int DIVISOR = UART_BAUD_DIVISOR
) (
    input  logic clk_100MHz,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: wrap to zero after the terminal value.
    always_comb begin
        count_d = count_q;
        if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + ONE;
        end
    end

    // Divider counter register.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule : baud_rate_generator

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, glitch-rejecting start detection,
// framing-error pulse and a break state that ignores a held-low line.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DBITS        = UART_DBITS,
    parameter int SB_TICK      = UART_OVERSAMPLE,
    parameter int BAUD_DIVISOR = UART_BAUD_DIVISOR
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             rx,
    output logic [DBITS-1:0] data_out,
    output logic             rx_done_tick,
    output logic             frame_error
);

    localparam int SW = $clog2((SB_TICK > UART_OVERSAMPLE) ? SB_TICK : UART_OVERSAMPLE);
    localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(UART_OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(UART_OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [SW-1:0] S_ONE  = SW'(1);
    localparam logic [NW-1:0] N_LAST = NW'(DBITS - 1);
    localparam logic [NW-1:0] N_ONE  = NW'(1);

    logic             tick_s;
    logic             rx_meta_q;
    logic             rx_s_q;

    rx_state_e        state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [NW-1:0]    n_q, n_d;
    logic [DBITS-1:0] b_q, b_d;
    logic [DBITS-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;

    baud_rate_generator #(
        .DIVISOR (BAUD_DIVISOR)
    ) u_baud (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .tick       (tick_s)
    );

    // Two-flop synchronizer; idles high so reset cannot fake a start edge.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state and datapath decode for the receive FSM.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            START: begin
                if (tick_s) begin
                    if (s_q == S_MID) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end else begin
                    s_d = s_q;
                end
            end

            DATA: begin
                if (tick_s) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = {rx_s_q, b_q[DBITS-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + N_ONE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end else begin
                    s_d = s_q;
                end
            end

            STOP: begin
                if (tick_s) begin
                    if (s_q == S_STOP) begin
                        if (rx_s_q) begin
                            data_d  = b_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end else begin
                    s_d = s_q;
                end
            end

            // A line held low after a bad stop bit must go high before re-arming.
            BREAK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = BREAK;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, counters, shift register and registered output pulses.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_out     = data_q;
    assign rx_done_tick = done_q;
    assign frame_error  = ferr_q;

endmodule : uart_rx

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver that deserializes 8N1 UART frames from the host line into bytes. It drives the capture FIFO directly: `data_out` connects to the FIFO write-data input, and `rx_done_tick` connects to the FIFO write strobe. Each received ASCII character therefore fills one FIFO slot. The receiver uses 16x oversampling from an internal baud tick and adds a framing-error indication.

Parameters:
- DBITS, 8: data bits per frame, sent LSB first.
- SB_TICK, 16: oversample ticks spent in the stop bit (16 = 1 stop bit).
- BAUD_DIVISOR, 651: clk_100MHz cycles per oversample tick (100e6 / (9600 × 16) ≈ 651).

Ports:
- clk_100MHz, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- rx, input, 1: asynchronous serial line; idles high.
- data_out, output, DBITS: last correctly received byte.
- rx_done_tick, output, 1: one-cycle pulse when data_out updates; this is the FIFO write strobe.
- frame_error, output, 1: one-cycle pulse when a frame's stop bit samples low.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE.
  - Tick counter s = 0, bit counter n = 0, shift register = 0.
  - data_out = 0, rx_done_tick = 0, frame_error = 0.
  - Synchronizer flops = 1; baud counter = 0.
- Reset mid-frame aborts the frame; no pulse is emitted.
- Input sync: rx passes through a 2-flop synchronizer; all logic uses the synchronized rx_s.
- Baud tick:
  - Free-running counter 0..BAUD_DIVISOR-1, width clog2(BAUD_DIVISOR).
  - `tick` is high for one clk when count = BAUD_DIVISOR-1, then count wraps to 0.
- FSM states: IDLE, START, DATA, STOP, BREAK. Counter s advances only on tick.
- IDLE:
  - rx_s = 0 → go to START with s = 0.
  - Otherwise stay in IDLE.
- START:
  - On tick with s = 7 (mid start bit): if rx_s = 0, go to DATA with s = 0, n = 0.
  - If rx_s = 1 at that sample, the start was a glitch → go to IDLE, no output.
- DATA:
  - On tick with s = 15: shift rx_s into the MSB (right shift, LSB first) and set s = 0.
  - If n = DBITS-1 → go to STOP; otherwise n = n + 1.
- STOP:
  - On tick with s = SB_TICK-1, sample rx_s.
  - rx_s = 1: data_out ← shift register, rx_done_tick = 1 for exactly one clk, go to IDLE.
  - rx_s = 0: frame_error = 1 for one clk; data_out is unchanged and no done tick is emitted; go to BREAK.
- BREAK:
  - Stay while rx_s = 0; go to IDLE on the first clk with rx_s = 1.
  - This prevents a held-low line from retriggering frames.
- Latency: rx_done_tick asserts on the clk edge that registers the stop-bit sample. That is roughly 9.5 bit times plus 2 synchronizer clks after the start-bit falling edge.
- data_out holds its value until the next good frame completes.
- Back-to-back frames: a start edge in the cycle right after STOP → IDLE is accepted. No dead time is needed beyond the stop bit.
- rx_done_tick and frame_error are mutually exclusive and never wider than one clk. The FIFO therefore sees exactly one write per good byte.
- The receiver has no backpressure. When the FIFO is full, the FIFO drops writes and the receiver ignores the condition.

Decomposition:
- Shared package:
  - constants UART_DBITS = 8, UART_OVERSAMPLE = 16, UART_BAUD_DIVISOR = 651;
  - state enum {IDLE, START, DATA, STOP, BREAK}.
- Sub-module baud_rate_generator:
  - parameter DIVISOR;
  - ports clk_100MHz, reset, tick.
  - Instantiated once inside uart_rx.
- The synchronizer and FSM stay in uart_rx.

Test Plan:
Benches run with BAUD_DIVISOR = 4, so one bit = 64 clk.
1. Send 0x41 ('A') 8N1 → data_out = 0x41; rx_done_tick high exactly 1 clk, about 610 clk after the falling edge; frame_error stays 0.
2. Pulse rx low for 20 clk (under half a bit), then high → no rx_done_tick, FSM back in IDLE, data_out unchanged (0x00 after reset).
3. Send 0x55 with stop bit = 0 and hold rx low for 200 clk, then high, then send 0x33 → one frame_error pulse with no done tick; FSM stays in BREAK while low; then data_out = 0x33 with one done tick.
4. Stream 32 back-to-back bytes 0x30..0x4F with no idle gap → 32 done pulses, each data_out matching in order; connected to the FIFO, the FIFO reports full after the 32nd.
5. Assert reset halfway through the data bits of 0x7E, release, then send 0x5A → no pulses for the aborted frame, all outputs 0 during reset, then data_out = 0x5A.
6. Drive bit periods at 62 and 66 clk (±3% skew) for 0xA5 → data_out = 0xA5 in both cases, frame_error = 0.
